intra_ang_sched: RTL and testbench
==================================

INTRA_ANG_SCHED -- requirements
Module: intra_ang_sched

Interface
REQ-001 SHALL have parameter SIZE_W, default 2, meaning width of the blk_size code (0=4x4, 1=8x8, 2=16x16, 3=32x32).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to schedule one prediction block.
REQ-005 SHALL have port ang  input  5  angle index 0..16 (-2,-5,-9,-13,-17,-21,-26,-32,0,2,5,9,13,17,21,26,32).
REQ-006 SHALL have port blk_size  input  SIZE_W  block size code.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-008 SHALL have port busy  output  1  block in progress.
REQ-009 SHALL have port out_valid  output  1  beat valid.
REQ-010 SHALL have port lut_ang  output  5  angle index for the weight LUT.
REQ-011 SHALL have port lut_ypos  output  3  4-row group index for the weight LUT.
REQ-012 SHALL have port col_grp  output  3  4-column group index.
REQ-013 SHALL have port ref_base  output  7  signed reference offset of the first row in the group.
REQ-014 SHALL have port last  output  1  marks the final beat of the block.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start, RUN->IDLE when the last beat is accepted.
REQ-017 SHALL capture ang and blk_size on the start edge and hold them for the whole block.
REQ-018 SHALL ignore start while busy=1, including start in the same cycle as done.
REQ-019 SHALL assert out_valid in the first cycle after start is captured (latency 1).
REQ-020 SHALL emit N*N beats, N=1<<blk_size, in order: col_grp inner (0..N-1), lut_ypos outer (0..N-1).
REQ-021 SHALL advance to the next beat only when out_valid and out_ready are both 1; all beat outputs SHALL stay stable while stalled.
REQ-022 SHALL drive lut_ang = captured ang while out_valid=1.
REQ-023 SHALL compute ref_base = ((4*lut_ypos+1)*A) arithmetically shifted right by 5, where A is the decoded signed angle; range -32..+32.
REQ-024 SHALL treat ang values 17..31 as angle 0 (index 8) for both lut_ang and ref_base.
REQ-025 SHALL assert last on the beat with lut_ypos=N-1 and col_grp=N-1; for 4x4, the single beat carries last.
REQ-026 SHALL pulse done for exactly one cycle, in the cycle after the last handshake, with busy=0 in that same cycle.
REQ-027 SHALL hold busy=1 from the cycle after start capture through the last handshake cycle.
REQ-028 SHALL drive out_valid=0 and last=0 whenever the FSM is IDLE.

Reset
REQ-029 SHALL force the FSM to IDLE immediately on rst=1, including mid-block, with no pending done pulse.
REQ-030 SHALL reset all outputs to 0: busy, out_valid, lut_ang, lut_ypos, col_grp, ref_base, last and done.

Configuration
REQ-031 SHALL recognise the macro INTRA_SCHED_STALL_CNT_EN; when it is defined, the module SHALL add output stall_cnt (16 bits), which counts cycles with out_valid=1 and out_ready=0, clears on each start capture and on rst, and saturates at 0xFFFF.
REQ-032 SHALL omit stall_cnt and all its logic when INTRA_SCHED_STALL_CNT_EN is undefined; all other behaviour SHALL be identical with or without the macro.

Verification
REQ-033 SHALL cover: ang=0, blk_size=0, out_ready=1 -> one beat with lut_ypos=0, col_grp=0, ref_base=-1, last=1; done on the next cycle.
REQ-034 SHALL cover: ang=11 (A=9), blk_size=1, out_ready=1 -> beats (y0,c0),(y0,c1),(y1,c0),(y1,c1); ref_base 0,0,1,1; last on the 4th beat.
REQ-035 SHALL cover: ang=16, blk_size=3, out_ready toggled every cycle -> 64 beats with no beat lost or duplicated; final ref_base=(29*32)>>5=29; stall_cnt=63 when the macro is enabled.
REQ-036 SHALL cover: start pulsed during RUN and in the done cycle -> both pulses are ignored; beat count remains N*N.
REQ-037 SHALL cover: rst asserted at beat 5 of a 16x16 block -> all outputs 0 in the same cycle; no done pulse; a new start runs normally.
REQ-038 SHALL cover: ang=20 with blk_size=1 -> lut_ang=8 and ref_base=0 on all 4 beats.

Source files
------------

// File: rtl/intra_ang_sched.sv
// Intra angular prediction beat scheduler: walks the 4x4 sub-block groups of one block and
// emits LUT angle/row indices plus row reference offsets. Optional macro INTRA_SCHED_STALL_CNT_EN adds stall_cnt.
module intra_ang_sched #(
    parameter int unsigned SIZE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        ang,
    input  logic [SIZE_W-1:0] blk_size,
    input  logic              out_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [4:0]        lut_ang,
    output logic [2:0]        lut_ypos,
    output logic [2:0]        col_grp,
    output logic [6:0]        ref_base,
`ifdef INTRA_SCHED_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              last,
    output logic              done
);
    localparam int unsigned ANG_W = 5;
    localparam int unsigned GRP_W = 3;
    localparam int unsigned REF_W = 7;
    localparam int unsigned AV_W  = 7;
    localparam int unsigned MUL_W = 12;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t                  state;
    logic signed [AV_W-1:0]  a_val;
    logic [GRP_W-1:0]        max_grp;
    logic [ANG_W-1:0]        ang_idx_c;
    logic signed [AV_W-1:0]  ang_val_c;
    logic [GRP_W-1:0]        max_grp_c;

    // Out-of-range indices fall back to the zero-angle entry.
    function automatic logic [ANG_W-1:0] ang_norm(input logic [ANG_W-1:0] a);
        return (a > ANG_W'(16)) ? ANG_W'(8) : a;
    endfunction

    function automatic logic signed [AV_W-1:0] ang_decode(input logic [ANG_W-1:0] idx);
        case (idx)
            5'd0:    return -7'sd2;
            5'd1:    return -7'sd5;
            5'd2:    return -7'sd9;
            5'd3:    return -7'sd13;
            5'd4:    return -7'sd17;
            5'd5:    return -7'sd21;
            5'd6:    return -7'sd26;
            5'd7:    return -7'sd32;
            5'd9:    return 7'sd2;
            5'd10:   return 7'sd5;
            5'd11:   return 7'sd9;
            5'd12:   return 7'sd13;
            5'd13:   return 7'sd17;
            5'd14:   return 7'sd21;
            5'd15:   return 7'sd26;
            5'd16:   return 7'sd32;
            default: return 7'sd0;
        endcase
    endfunction

    // Offset of the first row of a 4-row group: ((4*y+1)*A) >>> 5.
    function automatic logic [REF_W-1:0] calc_ref(input logic [GRP_W-1:0] y,
                                                  input logic signed [AV_W-1:0] a);
        logic signed [MUL_W-1:0] yv;
        logic signed [MUL_W-1:0] av;
        logic signed [MUL_W-1:0] prod;
        yv   = {7'b0, y, 2'b01};
        av   = {{(MUL_W-AV_W){a[AV_W-1]}}, a};
        prod = yv * av;
        return REF_W'(prod >>> 5);
    endfunction

    always_comb begin
        ang_idx_c = ang_norm(ang);
        ang_val_c = ang_decode(ang_idx_c);
        max_grp_c = GRP_W'((8'd1 << blk_size) - 8'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            lut_ang   <= '0;
            lut_ypos  <= '0;
            col_grp   <= '0;
            ref_base  <= '0;
            last      <= 1'b0;
            done      <= 1'b0;
            a_val     <= '0;
            max_grp   <= '0;
`ifdef INTRA_SCHED_STALL_CNT_EN
            stall_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with done still belongs to the finished block.
                    if (start && !done) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        lut_ang   <= ang_idx_c;
                        a_val     <= ang_val_c;
                        max_grp   <= max_grp_c;
                        lut_ypos  <= '0;
                        col_grp   <= '0;
                        ref_base  <= calc_ref('0, ang_val_c);
                        last      <= (max_grp_c == '0);
`ifdef INTRA_SCHED_STALL_CNT_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            last      <= 1'b0;
                            done      <= 1'b1;
                        end else if (col_grp == max_grp) begin
                            col_grp  <= '0;
                            lut_ypos <= lut_ypos + GRP_W'(1);
                            ref_base <= calc_ref(lut_ypos + GRP_W'(1), a_val);
                            last     <= 1'b0;
                        end else begin
                            col_grp <= col_grp + GRP_W'(1);
                            last    <= (lut_ypos == max_grp) && (col_grp + GRP_W'(1) == max_grp);
                        end
                    end
`ifdef INTRA_SCHED_STALL_CNT_EN
                    else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intra_ang_sched.sv
// Self-checking bench for intra_ang_sched: directed corner blocks plus random blocks against
// an arithmetic beat-list model.
module tb_intra_ang_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  ang;
    logic [1:0]  blk_size;
    logic        out_ready;
    logic        busy;
    logic        out_valid;
    logic [4:0]  lut_ang;
    logic [2:0]  lut_ypos;
    logic [2:0]  col_grp;
    logic [6:0]  ref_base;
    logic        last;
    logic        done;
`ifdef INTRA_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int ang_tab [17] = '{-2, -5, -9, -13, -17, -21, -26, -32, 0, 2, 5, 9, 13, 17, 21, 26, 32};

    intra_ang_sched #(.SIZE_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .ang(ang), .blk_size(blk_size),
        .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .lut_ang(lut_ang),
        .lut_ypos(lut_ypos), .col_grp(col_grp), .ref_base(ref_base),
`ifdef INTRA_SCHED_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .last(last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int norm_ang(input int a);
        return (a > 16) ? 8 : a;
    endfunction

    // Floor of (4y+1)*A / 32 for signed products.
    function automatic int exp_ref(input int a, input int y);
        int p;
        p = (4 * y + 1) * ang_tab[norm_ang(a)];
        if (p >= 0) return p / 32;
        return -((-p + 31) / 32);
    endfunction

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_last"},  int'(last), 0);
        check({tag, "_busy"},  int'(busy), 0);
    endtask

    task automatic run_block(input int a, input int sz, input int mode, input bit inject,
                             input int exp_stalls);
        int n, beats, k, cyc, stalls;
        bit hs;
        n = 1 << sz;
        beats = n * n;
        k = 0; cyc = 0; stalls = 0;
        ang = 5'(a); blk_size = 2'(sz); out_ready = pick_ready(mode, 0); start = 1'b1;
        step();
        start = 1'b0;
        while (k < beats && cyc < 5000) begin
            check("valid", int'(out_valid), 1);
            check("busy",  int'(busy), 1);
            check("done_run", int'(done), 0);
            check("lut_ang",  int'(lut_ang), norm_ang(a));
            check("lut_ypos", int'(lut_ypos), k / n);
            check("col_grp",  int'(col_grp), k % n);
            check("ref_base", int'($signed(ref_base)), exp_ref(a, k / n));
            check("last",     int'(last), (k == beats - 1) ? 1 : 0);
            if (!out_ready) stalls++;
            start = inject && (cyc == 2);
            if (start) ang = 5'($urandom_range(0, 31));
            hs = out_ready;
            step();
            start = 1'b0;
            cyc++;
            if (hs) k++;
            out_ready = pick_ready(mode, cyc);
        end
        check("beats_done", k, beats);
        check("done_pulse", int'(done), 1);
        check_idle_outputs("done_cycle");
`ifdef INTRA_SCHED_STALL_CNT_EN
        check("stall_cnt", int'(stall_cnt), stalls);
        if (exp_stalls >= 0) check("stall_cnt_exp", int'(stall_cnt), exp_stalls);
`endif
        start = inject;
        step();
        start = 1'b0;
        check("done_once", int'(done), 0);
        check_idle_outputs("after_done");
        step();
        check_idle_outputs("idle_hold");
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; ang = '0; blk_size = '0; out_ready = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_ref", int'(ref_base), 0);
        step();
        step();
        rst = 1'b0;
        step();
        check_idle_outputs("post_rst");

        run_block(0, 0, 0, 1'b0, 0);
        run_block(11, 1, 0, 1'b0, 0);
        run_block(16, 3, 1, 1'b0, 63);
        run_block(5, 2, 0, 1'b1, 0);
        run_block(20, 1, 0, 1'b0, 0);

        // Reset mid-block at beat 5 of a 16x16 block.
        ang = 5'd7; blk_size = 2'd2; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (k < 5) begin
            step();
            k++;
        end
        check("mid_ypos", int'(lut_ypos), 1);
        check("mid_col", int'(col_grp), 1);
        check("mid_ref", int'($signed(ref_base)), exp_ref(7, 1));
        rst = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ang", int'(lut_ang), 0);
        check("arst_ypos", int'(lut_ypos), 0);
        check("arst_col", int'(col_grp), 0);
        check("arst_ref", int'(ref_base), 0);
        check("arst_last", int'(last), 0);
        check("arst_done", int'(done), 0);
        step();
        rst = 1'b0;
        step();
        check("post_arst_done", int'(done), 0);
        check_idle_outputs("post_arst");
        step();
        check("post_arst_done2", int'(done), 0);
        run_block(13, 2, 0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            run_block(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 2,
                      1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
